// File: rtl/neuron_pkg.sv
// ---------------------------------------------------------------------------
// neuron_pkg
// Shared definitions for the neuron MAC sequencer:
//   - state_e        : sequencer FSM states
//   - DEF_* params   : default datapath widths and Q-format fraction bits
//   - sat_add        : signed add that clamps to a given width instead of
//                      wrapping (operands carried sign-extended in 64 bits)
// ---------------------------------------------------------------------------
package neuron_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ACC_WIDTH  = 32;
  localparam int DEF_FRAC_BITS  = 8;
  localparam int DEF_CNT_WIDTH  = 10;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCUM    = 2'd1,
    SATURATE = 2'd2,
    OUTPUT   = 2'd3
  } state_e;

  // Both operands must already be sign-extended to 64 bits and be
  // representable in 'width' bits. The sum is formed one bit wider so
  // it can never overflow, then clamped to the signed range of 'width'.
  function automatic logic signed [63:0] sat_add(
    input logic signed [63:0] a,
    input logic signed [63:0] b,
    input int                 width
  );
    logic signed [64:0] sum;
    logic signed [64:0] maxVal;
    logic signed [64:0] minVal;
    sum    = 65'(a) + 65'(b);
    maxVal = (65'sd1 <<< (width - 1)) - 65'sd1;
    minVal = -(65'sd1 <<< (width - 1));
    if (sum > maxVal) begin
      sat_add = 64'(maxVal);
    end else if (sum < minVal) begin
      sat_add = 64'(minVal);
    end else begin
      sat_add = 64'(sum);
    end
  endfunction

endpackage

// File: rtl/overflow_underflow_rectifier.sv
// ---------------------------------------------------------------------------
// overflow_underflow_rectifier
// Narrows a signed value from UNRECTIFIED_DATA_WIDTH to RECTIFIED_DATA_WIDTH,
// saturating to the positive or negative rail when it does not fit.
// Purely combinational.
//
// Ports:
//   data_i  signed [UNRECTIFIED_DATA_WIDTH-1:0]  wide value
//   data_o  signed [RECTIFIED_DATA_WIDTH-1:0]    saturated narrow value
// ---------------------------------------------------------------------------
module overflow_underflow_rectifier #(
  parameter int UNRECTIFIED_DATA_WIDTH = 32,
  parameter int RECTIFIED_DATA_WIDTH   = 16
) (
  input  logic signed [UNRECTIFIED_DATA_WIDTH-1:0] data_i,
  output logic signed [RECTIFIED_DATA_WIDTH-1:0]   data_o
);

  localparam int U = UNRECTIFIED_DATA_WIDTH;
  localparam int R = RECTIFIED_DATA_WIDTH;

  logic [U-R:0] upperBits;
  logic         fits;

  // The value fits exactly when every bit from the narrow sign bit upward
  // is a copy of the same sign.
  always_comb begin
    upperBits = data_i[U-1:R-1];
    fits      = (&upperBits) | (~|upperBits);
    if (fits) begin
      data_o = data_i[R-1:0];
    end else if (data_i[U-1]) begin
      data_o = {1'b1, {(R-1){1'b0}}};
    end else begin
      data_o = {1'b0, {(R-1){1'b1}}};
    end
  end

endmodule

// File: rtl/neuron_mac_sequencer.sv
// ---------------------------------------------------------------------------
// neuron_mac_sequencer
// Evaluates one neuron: loads a bias, multiply-accumulates a stream of
// Q-format input/weight pairs into a saturating ACC_WIDTH accumulator, then
// narrows the sum to DATA_WIDTH and presents it on a valid/ready output.
//
// Build option:
//   NEURON_RELU_EN  when defined, negative narrowed results are forced to 0
//                   before being registered (same latency either way).
//
// Ports:
//   clk_in             clock, rising edge
//   rst_in             asynchronous active-high reset
//   start_in           begin a neuron (sampled only in IDLE)
//   num_inputs_in      operand pairs to consume (latched on start)
//   bias_in            signed bias (latched on start)
//   x_in, w_in         signed operand pair
//   operand_valid_in   operand pair valid
//   operand_ready_out  sequencer accepts the operand pair
//   result_out         saturated neuron result
//   result_valid_out   result_out valid
//   result_ready_in    downstream accepts the result
//   busy_out           high whenever not IDLE
// ---------------------------------------------------------------------------
module neuron_mac_sequencer
  import neuron_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int FRAC_BITS  = DEF_FRAC_BITS,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         start_in,
  input  logic        [CNT_WIDTH-1:0]  num_inputs_in,
  input  logic signed [DATA_WIDTH-1:0] bias_in,
  input  logic signed [DATA_WIDTH-1:0] x_in,
  input  logic signed [DATA_WIDTH-1:0] w_in,
  input  logic                         operand_valid_in,
  output logic                         operand_ready_out,
  output logic signed [DATA_WIDTH-1:0] result_out,
  output logic                         result_valid_out,
  input  logic                         result_ready_in,
  output logic                         busy_out
);

  state_e                        state_q;
  logic signed [ACC_WIDTH-1:0]   accum_q;
  logic        [CNT_WIDTH-1:0]   remaining_q;
  logic signed [DATA_WIDTH-1:0]  result_q;
  logic                          resultValid_q;
  logic                          operandReady_q;
  logic                          busy_q;

  logic signed [2*DATA_WIDTH-1:0] product;
  logic signed [2*DATA_WIDTH-1:0] productShifted;
  logic signed [ACC_WIDTH-1:0]    accum_d;
  logic signed [DATA_WIDTH-1:0]   rectified;
  logic signed [DATA_WIDTH-1:0]   result_d;

  // Full-precision product, realigned to the Q format, then added onto the
  // accumulator with clamping at ACC_WIDTH rather than wrap-around.
  always_comb begin
    product        = x_in * w_in;
    productShifted = product >>> FRAC_BITS;
    accum_d        = ACC_WIDTH'(sat_add(64'(accum_q), 64'(productShifted), ACC_WIDTH));
  end

  overflow_underflow_rectifier #(
    .UNRECTIFIED_DATA_WIDTH (ACC_WIDTH),
    .RECTIFIED_DATA_WIDTH   (DATA_WIDTH)
  ) u_rectifier (
    .data_i (accum_q),
    .data_o (rectified)
  );

  // Optional ReLU applied after narrowing.
  always_comb begin
`ifdef NEURON_RELU_EN
    result_d = rectified[DATA_WIDTH-1] ? '0 : rectified;
`else
    result_d = rectified;
`endif
  end

  // Sequencer FSM; all handshake outputs are registered alongside state.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q        <= IDLE;
      accum_q        <= '0;
      remaining_q    <= '0;
      result_q       <= '0;
      resultValid_q  <= 1'b0;
      operandReady_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_in) begin
            accum_q     <= ACC_WIDTH'(bias_in);
            remaining_q <= num_inputs_in;
            busy_q      <= 1'b1;
            if (num_inputs_in == '0) begin
              state_q <= SATURATE;
            end else begin
              state_q        <= ACCUM;
              operandReady_q <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (operand_valid_in && operandReady_q) begin
            accum_q     <= accum_d;
            remaining_q <= remaining_q - CNT_WIDTH'(1);
            if (remaining_q == CNT_WIDTH'(1)) begin
              state_q        <= SATURATE;
              operandReady_q <= 1'b0;
            end
          end
        end
        SATURATE: begin
          result_q      <= result_d;
          resultValid_q <= 1'b1;
          state_q       <= OUTPUT;
        end
        OUTPUT: begin
          if (result_ready_in) begin
            resultValid_q <= 1'b0;
            busy_q        <= 1'b0;
            state_q       <= IDLE;
          end
        end
        default: begin
          state_q        <= IDLE;
          operandReady_q <= 1'b0;
          resultValid_q  <= 1'b0;
          busy_q         <= 1'b0;
        end
      endcase
    end
  end

  assign operand_ready_out = operandReady_q;
  assign result_out        = result_q;
  assign result_valid_out  = resultValid_q;
  assign busy_out          = busy_q;

endmodule

// File: doc/neuron_mac_sequencer.md
Name: neuron_mac_sequencer

Overview:
Sequences one neuron evaluation: accepts a stream of input/weight operand pairs, multiply-accumulates them at ACC_WIDTH onto a bias, then narrows the sum to DATA_WIDTH through the saturating overflow_underflow_rectifier. Results leave on a valid/ready output. Sits between the layer scheduler (start/operand stream) and the activation/writeback stage.

Parameters:
DATA_WIDTH, 16, signed fixed-point width of inputs, weights, bias, result
ACC_WIDTH, 32, signed accumulator width; rectifier input width
FRAC_BITS, 8, fractional bits of the Q format; products are shifted right arithmetically by this
CNT_WIDTH, 10, width of the operand count

Ports:
clk_in  input  1  system clock, rising-edge
rst_in  input  1  asynchronous, active-high reset
start_in  input  1  begin a neuron; sampled only in IDLE
num_inputs_in  input  CNT_WIDTH  operand pairs to consume; latched on start
bias_in  input  DATA_WIDTH  signed bias; latched on start
x_in  input  DATA_WIDTH  signed activation operand
w_in  input  DATA_WIDTH  signed weight operand
operand_valid_in  input  1  x_in/w_in valid
operand_ready_out  output  1  sequencer accepts operand pair
result_out  output  DATA_WIDTH  saturated neuron result
result_valid_out  output  1  result_out valid
result_ready_in  input  1  downstream accepts result
busy_out  output  1  high in any state except IDLE

Behaviour:
- Reset (async, active-high): state=IDLE, accumulator=0, count=0; operand_ready_out=0, result_valid_out=0, result_out=0, busy_out=0.
- States: IDLE, ACCUM, SATURATE, OUTPUT.
- IDLE: on start_in, accumulator := sign-extended bias_in; remaining := num_inputs_in. If num_inputs_in==0 -> SATURATE, else -> ACCUM.
- ACCUM: operand_ready_out=1. Each cycle with operand_valid_in && operand_ready_out: product = x_in*w_in (2*DATA_WIDTH signed), shifted >>> FRAC_BITS, sign-extended to ACC_WIDTH, added to accumulator with saturation at ACC_WIDTH (clamp to 2^(ACC_WIDTH-1)-1 or -2^(ACC_WIDTH-1); no wrap). remaining decrements; on the handshake where remaining==1 -> SATURATE. One pair per cycle max.
- SATURATE: operand_ready_out=0; accumulator passes through the rectifier; result_out registered; -> OUTPUT.
- OUTPUT: result_valid_out=1, result_out held stable until result_ready_in; on handshake result_valid_out drops next cycle, -> IDLE.
- Latency: result_valid_out rises 2 cycles after the final operand handshake (or 2 cycles after start with num_inputs_in==0).
- start_in outside IDLE ignored; num_inputs_in/bias_in changes after start ignored.
- operand_valid_in outside ACCUM ignored (no handshake).
- Reset in any state aborts; partial sum discarded; no result emitted.
- Back-to-back: start_in may be accepted the cycle after the OUTPUT handshake (one IDLE cycle minimum).

Optional Feature:
NEURON_RELU_EN: when defined, SATURATE applies ReLU after rectification: negative results become 0, non-negative unchanged. When undefined, the signed saturated value is output unmodified. Latency identical either way.

Decomposition:
- Package neuron_pkg: state enum (IDLE, ACCUM, SATURATE, OUTPUT), default DATA_WIDTH/ACC_WIDTH/FRAC_BITS constants, saturating-add function.
- Sub-module: overflow_underflow_rectifier (UNRECTIFIED_DATA_WIDTH=ACC_WIDTH, RECTIFIED_DATA_WIDTH=DATA_WIDTH), instantiated once; all sequencing stays in this block.

Test Plan:
- num=3, bias=0x0080, three pairs x=0x0100 w=0x0200 -> result_out=0x0680, result_valid_out 2 cycles after third handshake.
- num=0, bias=0xFF00 -> result_out=0xFF00 two cycles after start, no operand_ready_out pulse.
- num=4, x=0x7FFF w=0x7FFF -> 0x7FFF; num=4, x=0x8000 w=0x7FFF -> 0x8000 (narrowing saturation both rails).
- operand_valid_in toggled 1/0 each cycle, result_ready_in held low 5 cycles -> same result as steady stream; result_out stable, start_in ignored, busy_out=1 throughout.
- rst_in pulsed after 2 of 4 operands -> all outputs 0 immediately; next neuron (num=1, bias=0, x=0x0100 w=0x0100) -> 0x0100.
- NEURON_RELU_EN defined, num=1, bias=0, x=0xFF00 w=0x0100 -> 0x0000; undefined -> 0xFF00.
